// File: rtl/data_write_buffer_pkg.sv
// Shared bus definitions for the core data port, the write buffer and the bridge.
// A queued store entry is addr/size/wstrb/wdata packed into 70 bits.
package data_write_buffer_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int SIZE_W = 2;
  localparam int ENTRY_W = ADDR_W + SIZE_W + STRB_W + DATA_W;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_4B = 2'd2
  } size_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Synchronous DEPTH-entry FIFO holding posted stores; head is visible combinationally.
module wbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 70,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(i_push && o_full));
      assert (!(i_pop && o_empty));
    end
  end

endmodule

// File: rtl/data_write_buffer.sv
// Posted-write buffer between the core data port and the bridge data port.
// Stores are acked once queued and drained in order; loads wait for all stores to complete.
module data_write_buffer
  import data_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [SIZE_W-1:0] cpu_size,
  input  logic [STRB_W-1:0] cpu_wstrb,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_addr_ok,
  output logic              cpu_data_ok,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wbuf_entry_t      w_push_entry;
  wbuf_entry_t      w_head_entry;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_wr_accept;
  logic             w_drain;
  logic             w_rd_pass;
  logic             w_pop;
  logic             w_wr_done;

  logic [CNT_W-1:0] r_wr_out;
  logic             r_rd_busy;
  logic             r_wr_ack;

  assign w_push_entry = '{addr: cpu_addr, size: cpu_size, wstrb: cpu_wstrb, wdata: cpu_wdata};

  wbuf_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .i_push (w_wr_accept),
    .i_pop  (w_pop),
    .i_din  (w_push_entry),
    .o_dout (w_head_entry),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty),
    .o_count(w_fifo_count)
  );

  // Handshake outputs are qualified with resetn so they drop the moment reset asserts.
  assign w_wr_accept = resetn && cpu_req && cpu_wr && !w_fifo_full && !r_rd_busy;
  assign w_drain     = resetn && !w_fifo_empty && !r_rd_busy;
  assign w_rd_pass   = resetn && cpu_req && !cpu_wr && w_fifo_empty &&
                       (r_wr_out == '0) && !r_rd_busy;
  assign w_pop       = w_drain && mem_addr_ok;
  assign w_wr_done   = mem_data_ok && !r_rd_busy;

  assign cpu_addr_ok = w_wr_accept || (w_rd_pass && mem_addr_ok);
  assign cpu_data_ok = resetn && (r_wr_ack || (r_rd_busy && mem_data_ok));
  assign cpu_rdata   = mem_rdata;

  // Drain and load pass-through are exclusive: a load needs an empty FIFO.
  always_comb begin
    mem_req   = w_drain || w_rd_pass;
    mem_wr    = 1'b0;
    mem_size  = cpu_size;
    mem_wstrb = cpu_wstrb;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (w_drain) begin
      mem_wr    = 1'b1;
      mem_size  = w_head_entry.size;
      mem_wstrb = w_head_entry.wstrb;
      mem_addr  = w_head_entry.addr;
      mem_wdata = w_head_entry.wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_out  <= '0;
      r_rd_busy <= 1'b0;
      r_wr_ack  <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_accept;
      if (w_rd_pass && mem_addr_ok) begin
        r_rd_busy <= 1'b1;
      end else if (r_rd_busy && mem_data_ok) begin
        r_rd_busy <= 1'b0;
      end
      if (w_pop && !w_wr_done) begin
        r_wr_out <= r_wr_out + CNT_W'(1);
      end else if (!w_pop && w_wr_done) begin
        r_wr_out <= r_wr_out - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(w_pop && !w_wr_done && (r_wr_out == CNT_W'(DEPTH))));
      assert (!(w_wr_done && !w_pop && (r_wr_out == '0)));
      assert (w_fifo_count <= CNT_W'(DEPTH));
      assert (!(cpu_req && (cpu_size > SIZE_4B)));
    end
  end

endmodule

// File: tb/tb_data_write_buffer.sv
// Randomized bench for data_write_buffer: a driver plays core and bridge, a monitor
// checks the DUT against a transaction-level model of posted stores and ordered loads.
module tb_data_write_buffer;
  import data_write_buffer_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    bit          wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          due;
    bit          isRead;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    bit          isRead;
    int          due;
    logic [31:0] data;
  } cpu_exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [1:0]  cpu_size = 2'd0;
  logic [3:0]  cpu_wstrb = 4'd0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  req_t        dirQ[$];
  resp_t       respQ[$];
  cpu_exp_t    expCpuQ[$];
  req_t        expMemQ[$];
  logic [31:0] refMem[int];
  logic [31:0] bMem[int];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int reqPct = 0;
  int addrOkPct = 100;
  int dlyMin = 1;
  int dlyMax = 1;
  int wrAccepted = 0;
  int memWrHs = 0;
  int memWrDone = 0;
  bit active = 0;
  bit cpuHs = 0;
  bit respCurIsRead = 0;
  bit readBusy = 0;
  bit prevStall = 0;
  req_t        cur;
  logic [31:0] prevAddr, prevWdata;
  logic [1:0]  prevSize;
  logic [3:0]  prevStrb;
  logic        prevWr;

  data_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_size   (cpu_size),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok),
    .cpu_rdata  (cpu_rdata),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_size   (mem_size),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] initVal(int key);
    logic [31:0] k;
    k = 32'(key);
    return {k[15:0] ^ 16'h5A5A, ~k[15:0]};
  endfunction

  function automatic logic [31:0] memRead(int key, bit useRef);
    if (useRef) return refMem.exists(key) ? refMem[key] : initVal(key);
    return bMem.exists(key) ? bMem[key] : initVal(key);
  endfunction

  function automatic logic [31:0] mergeBytes(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  function automatic req_t mkReq(bit wr, logic [1:0] size, logic [3:0] s,
                                 logic [31:0] a, logic [31:0] d);
    req_t r;
    r.wr = wr; r.size = size; r.wstrb = s; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic req_t randomReq();
    req_t r;
    int sz, lane;
    r.wr = ($urandom_range(0, 1) == 1);
    sz = int'($urandom_range(0, 2));
    r.size = 2'(sz);
    if (sz == 0) begin
      lane = int'($urandom_range(0, 3));
      r.wstrb = 4'(1 << lane);
    end else if (sz == 1) begin
      lane = 2 * int'($urandom_range(0, 1));
      r.wstrb = 4'(3 << lane);
    end else begin
      lane = 0;
      r.wstrb = 4'hF;
    end
    r.addr = 32'h1000 * $urandom_range(1, 4) + 32'(lane);
    r.wdata = $urandom;
    return r;
  endfunction

  // Core side holds each request until addr_ok; bridge returns responses in order.
  task automatic applyStimulus();
    resp_t r;
    if (!resetn) begin
      active = 0; cpuHs = 0;
      cpu_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; respCurIsRead = 0;
      return;
    end
    if (active && cpuHs) active = 0;
    cpuHs = 0;
    if (!active) begin
      if (dirQ.size() > 0) begin
        cur = dirQ.pop_front(); active = 1;
      end else if (int'($urandom_range(0, 99)) < reqPct) begin
        cur = randomReq(); active = 1;
      end
    end
    cpu_req = active; cpu_wr = cur.wr; cpu_size = cur.size;
    cpu_wstrb = cur.wstrb; cpu_addr = cur.addr; cpu_wdata = cur.wdata;
    mem_addr_ok = (int'($urandom_range(0, 99)) < addrOkPct);
    if (respQ.size() > 0 && respQ[0].due <= cyc) begin
      r = respQ.pop_front();
      mem_data_ok = 1'b1; mem_rdata = r.data; respCurIsRead = r.isRead;
    end else begin
      mem_data_ok = 1'b0; mem_rdata = $urandom; respCurIsRead = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    applyStimulus();
  end

  // Monitor: expectations are formed from the model state at the start of the cycle.
  task automatic sampleCycle();
    int q, inflight, key;
    bit rdEligible, expDataOk;
    req_t e;
    cpu_exp_t c;
    q = wrAccepted - memWrHs;
    inflight = memWrHs - memWrDone;
    rdEligible = cpu_req && !cpu_wr && (q == 0) && (inflight == 0) && !readBusy;

    if (prevStall) begin
      checkOutput("mem_hold_req", 32'(mem_req), 32'd1);
      checkOutput("mem_hold_addr", mem_addr, prevAddr);
      checkOutput("mem_hold_wdata", mem_wdata, prevWdata);
      checkOutput("mem_hold_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
                  {25'd0, prevWr, prevSize, prevStrb});
    end
    checkOutput("mem_req", 32'(mem_req), 32'(!readBusy && (q > 0 || rdEligible)));
    if (q > 0 && !readBusy) checkOutput("mem_wr_drain", 32'(mem_wr), 32'd1);
    if (cpu_req && cpu_wr)
      checkOutput("wr_addr_ok", 32'(cpu_addr_ok), 32'((q < DEPTH) && !readBusy));
    if (cpu_req && !cpu_wr) begin
      checkOutput("rd_addr_ok", 32'(cpu_addr_ok), 32'(rdEligible && mem_addr_ok));
      if (rdEligible) begin
        checkOutput("rd_pass_wr", 32'(mem_wr), 32'd0);
        checkOutput("rd_pass_addr", mem_addr, cpu_addr);
        checkOutput("rd_pass_size", 32'(mem_size), 32'(cpu_size));
      end
    end
    if (!cpu_req) checkOutput("idle_addr_ok", 32'(cpu_addr_ok), 32'd0);

    expDataOk = (expCpuQ.size() > 0 && !expCpuQ[0].isRead && expCpuQ[0].due == cyc) ||
                (mem_data_ok && respCurIsRead);
    checkOutput("cpu_data_ok", 32'(cpu_data_ok), 32'(expDataOk));
    if (cpu_data_ok && expDataOk && expCpuQ.size() > 0) begin
      c = expCpuQ.pop_front();
      if (c.isRead) checkOutput("rd_data", cpu_rdata, c.data);
    end
    if (mem_data_ok && respCurIsRead) readBusy = 0;
    if (mem_data_ok && !respCurIsRead) memWrDone++;

    if (mem_req && mem_addr_ok) begin
      key = int'(mem_addr >> 2);
      if (mem_wr) begin
        if (expMemQ.size() > 0) begin
          e = expMemQ.pop_front();
          checkOutput("mem_wr_addr", mem_addr, e.addr);
          checkOutput("mem_wr_data", mem_wdata, e.wdata);
          checkOutput("mem_wr_size_strb", {26'd0, mem_size, mem_wstrb}, {26'd0, e.size, e.wstrb});
        end else begin
          compared++; mismatched++;
          $display("[TB] FAIL mem_extra_write: got write to %h expected no write", mem_addr);
        end
        bMem[key] = mergeBytes(memRead(key, 1'b0), mem_wdata, mem_wstrb);
        memWrHs++;
        respQ.push_back('{due: cyc + int'($urandom_range(dlyMin, dlyMax)), isRead: 1'b0, data: 32'h0});
      end else begin
        respQ.push_back('{due: cyc + int'($urandom_range(dlyMin, dlyMax)), isRead: 1'b1,
                          data: memRead(key, 1'b0)});
      end
    end

    if (cpu_req && cpu_addr_ok) begin
      cpuHs = 1;
      key = int'(cpu_addr >> 2);
      if (cpu_wr) begin
        expMemQ.push_back(mkReq(1'b1, cpu_size, cpu_wstrb, cpu_addr, cpu_wdata));
        refMem[key] = mergeBytes(memRead(key, 1'b1), cpu_wdata, cpu_wstrb);
        wrAccepted++;
        expCpuQ.push_back('{isRead: 1'b0, due: cyc + 1, data: 32'h0});
      end else begin
        expCpuQ.push_back('{isRead: 1'b1, due: 0, data: memRead(key, 1'b1)});
        readBusy = 1;
      end
    end

    prevStall = mem_req && !mem_addr_ok;
    prevAddr = mem_addr; prevWdata = mem_wdata; prevSize = mem_size;
    prevStrb = mem_wstrb; prevWr = mem_wr;
  endtask

  initial forever begin
    @(negedge clk);
    if (resetn) sampleCycle();
  end

  task automatic clearModel();
    dirQ.delete(); respQ.delete(); expCpuQ.delete(); expMemQ.delete();
    wrAccepted = 0; memWrHs = 0; memWrDone = 0;
    readBusy = 0; prevStall = 0; active = 0; cpuHs = 0;
    refMem = bMem;
  endtask

  task automatic checkResetOutputs(string tag);
    cpu_req = 1'b1; cpu_wr = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    checkOutput({tag, "_wr_addr_ok"}, 32'(cpu_addr_ok), 32'd0);
    checkOutput({tag, "_data_ok"}, 32'(cpu_data_ok), 32'd0);
    checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    cpu_wr = 1'b0;
    #1;
    checkOutput({tag, "_rd_addr_ok"}, 32'(cpu_addr_ok), 32'd0);
    checkOutput({tag, "_rd_mem_req"}, 32'(mem_req), 32'd0);
  endtask

  task automatic doReset(string tag, int holdCycles);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    checkResetOutputs(tag);
    clearModel();
    repeat (holdCycles) @(posedge clk);
    #3;
    resetn = 1'b1;
  endtask

  task automatic waitIdle(string tag, int budget);
    int n;
    n = 0;
    while ((dirQ.size() > 0 || active || expCpuQ.size() > 0 || expMemQ.size() > 0 ||
            respQ.size() > 0 || readBusy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle_reached"}, 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    compared++; mismatched++;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    $display("[TB] start");
    #2;
    checkResetOutputs("por");
    cpu_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;

    // Single store, bridge always ready.
    addrOkPct = 100; dlyMin = 1; dlyMax = 2;
    dirQ.push_back(mkReq(1'b1, SIZE_4B, 4'hF, 32'h1000, 32'hDEADBEEF));
    waitIdle("single_store", 50);

    // Five stores into a four-entry FIFO with the bridge stalled.
    addrOkPct = 0;
    for (int i = 0; i < 5; i++)
      dirQ.push_back(mkReq(1'b1, SIZE_4B, 4'hF, 32'h1100 + 32'(4 * i), 32'hA0000000 + 32'(i)));
    repeat (10) @(posedge clk);
    addrOkPct = 100;
    waitIdle("fill", 80);

    // Store then load of the same word with a three-cycle bridge response.
    dlyMin = 3; dlyMax = 3;
    dirQ.push_back(mkReq(1'b1, SIZE_4B, 4'hF, 32'h2000, 32'h11223344));
    dirQ.push_back(mkReq(1'b0, SIZE_4B, 4'hF, 32'h2000, 32'h0));
    waitIdle("store_load", 80);

    // Load with nothing buffered, then a byte store and read-back.
    dlyMin = 1; dlyMax = 2;
    dirQ.push_back(mkReq(1'b0, SIZE_4B, 4'hF, 32'h1000, 32'h0));
    waitIdle("empty_load", 50);
    dirQ.push_back(mkReq(1'b1, SIZE_1B, 4'h4, 32'h3002, 32'hAABBCCDD));
    dirQ.push_back(mkReq(1'b0, SIZE_4B, 4'hF, 32'h3000, 32'h0));
    waitIdle("byte_store", 60);

    // Random traffic with alternating bridge back-pressure.
    dlyMin = 1; dlyMax = 4;
    for (int blk = 0; blk < 6; blk++) begin
      addrOkPct = (blk % 2 == 0) ? 20 : 90;
      reqPct = 60;
      repeat (250) @(posedge clk);
    end
    reqPct = 0; addrOkPct = 70;
    waitIdle("random", 400);

    // Reset with stores queued behind a stalled bridge.
    addrOkPct = 0;
    for (int i = 0; i < 3; i++)
      dirQ.push_back(mkReq(1'b1, SIZE_4B, 4'hF, 32'h4000 + 32'(4 * i), $urandom));
    repeat (6) @(posedge clk);
    doReset("rst_queued", 3);
    addrOkPct = 100;
    dirQ.push_back(mkReq(1'b1, SIZE_2B, 4'hC, 32'h4002, 32'h55667788));
    dirQ.push_back(mkReq(1'b0, SIZE_4B, 4'hF, 32'h4000, 32'h0));
    waitIdle("post_rst", 60);

    // Reset while a load is outstanding at the bridge.
    dlyMin = 20; dlyMax = 20;
    dirQ.push_back(mkReq(1'b0, SIZE_4B, 4'hF, 32'h2000, 32'h0));
    repeat (6) @(posedge clk);
    doReset("rst_rdbusy", 2);
    dlyMin = 1; dlyMax = 3;
    dirQ.push_back(mkReq(1'b1, SIZE_4B, 4'hF, 32'h2000, 32'hCAFEF00D));
    dirQ.push_back(mkReq(1'b0, SIZE_4B, 4'hF, 32'h2000, 32'h0));
    waitIdle("post_rst2", 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_write_buffer.md
# data_write_buffer

Posted-write buffer between the CPU core's data SRAM-like port and the data port of the SRAM-to-AXI bridge. Stores are acknowledged to the core as soon as they are queued and are drained in order to the bridge; reads are forwarded only after every earlier store has completed, so memory ordering is strict. The inst port is not involved; the block is transparent to the core except for lower store latency.

## Interface
- DEPTH, 4: entries in the store FIFO; power of two, ≥2.
- clk  in  1  system clock (same as core/bridge `clk`).
- resetn  in  1  asynchronous, active-low reset.
- cpu_req, cpu_wr  in  1 each  core request / write flag.
- cpu_size  in  2  byte-count code (0=1B, 1=2B, 2=4B).
- cpu_wstrb  in  4  byte enables (writes).
- cpu_addr, cpu_wdata  in  32 each.
- cpu_addr_ok  out  1  request accepted this cycle.
- cpu_data_ok  out  1  one pulse per accepted request, in acceptance order.
- cpu_rdata  out  32  read data, valid with cpu_data_ok of a read.
- mem_req, mem_wr  out  1 each  request to bridge.
- mem_size  out  2; mem_wstrb  out  4; mem_addr, mem_wdata  out  32.
- mem_addr_ok, mem_data_ok  in  1 each  bridge handshakes.
- mem_rdata  in  32  bridge read data.

## Operation
- State: FIFO (addr, size, wstrb, wdata; 70 bits), count 0..DEPTH, wr_out counter 0..DEPTH (writes handed to bridge awaiting mem_data_ok), rd_busy flag, wr_ack register.
- Write accept: cpu_req & cpu_wr & count<DEPTH & !rd_busy → cpu_addr_ok=1, push; wr_ack set, cpu_data_ok=1 the next cycle.
- Drain: count>0 & !rd_busy → mem_req=1, mem_wr=1, fields from FIFO head; on mem_addr_ok pop head and wr_out+1. Each mem_data_ok while !rd_busy: wr_out−1.
- Read accept: cpu_req & !cpu_wr & count==0 & wr_out==0 & !rd_busy → pass-through: mem_req=1, mem_wr=0, cpu fields to mem; cpu_addr_ok=mem_addr_ok; on handshake set rd_busy.
- Read return: rd_busy & mem_data_ok → cpu_data_ok=1, cpu_rdata=mem_rdata, clear rd_busy.
- Read blocked (FIFO/wr_out non-zero): cpu_addr_ok=0, draining continues.
- While rd_busy: no CPU request accepted, no drain issued.
- Full FIFO: write stalls (cpu_addr_ok=0) even if a pop occurs that cycle; no same-cycle full bypass.
- Simultaneous push and pop: count unchanged; pointers advance independently, wrap modulo DEPTH.
- cpu_data_ok sources never collide: a read is accepted at least one cycle after the last wr_ack.
- cpu_rdata is don't-care outside read cpu_data_ok; drive mem_rdata directly.

## Timing
- Reset (async, resetn low): count, pointers, wr_out, rd_busy, wr_ack = 0; cpu_addr_ok, cpu_data_ok, mem_req forced 0 while resetn low. In-flight bridge transactions are abandoned; the bridge is reset by the same resetn.
- Store: addr_ok cycle T, data_ok T+1; earliest mem_req for that entry T+1 (no empty-FIFO bypass).
- Load with empty buffer: combinational pass-through; latency = bridge latency, zero added cycles.
- Load behind N queued stores: held until every store's mem_data_ok has returned.
- mem_* outputs stable while mem_req=1 and mem_addr_ok=0 (head entry does not change; pass-through follows the core, which holds its request).
- Counter widths $clog2(DEPTH+1); overflow impossible by the accept/issue guards; assert in simulation.

## Structure
- Shared bus package: SIZE_* codes, entry field widths, entry pack/unpack constants (shared with core and bridge).
- Sub-module `wbuf_fifo`: synchronous DEPTH×70 FIFO with push/pop/full/empty/count, async active-low reset; controller stays in the top.

## Test plan
- Single store 0x1000/0xDEADBEEF, wstrb 0xF: addr_ok T, data_ok T+1, mem write T+1 with identical fields, wr_out back to 0 after mem_data_ok.
- 5 back-to-back stores, DEPTH=4, bridge mem_addr_ok held 0: 4 accepted, 5th stalls until first pop, then accepted next cycle; order preserved at mem side.
- Store 0x2000=0x11223344 then load 0x2000, bridge data_ok delay 3: load addr_ok only after store's mem_data_ok; load returns bridge data with one cpu_data_ok.
- Load with empty buffer: mem_req same cycle as cpu_req, cpu_addr_ok = mem_addr_ok, zero added latency.
- Byte store size=0, wstrb 0x4, addr 0x3002: mem_size=0, wstrb=0x4 forwarded unchanged.
- resetn low with 3 queued stores and rd_busy: all outputs 0 immediately; after release count=0, next store handled normally.
